// File: rtl/free_list.sv
// Circular FIFO of free physical-register tags for the rename path.
// Supplies up to WAY tags per cycle, reclaims retired Told tags and restores the retired state on rollback.
module free_list #(
  parameter int WAY    = 3,
  parameter int NUM_PR = 64,
  parameter int NUM_AR = 32,
  localparam int DEPTH  = NUM_PR - NUM_AR,
  localparam int PR_W   = $clog2(NUM_PR),
  localparam int CNT_W  = $clog2(WAY + 1),
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int FCNT_W = $clog2(DEPTH + 1)
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [CNT_W-1:0]           dispatch_num,
  input  logic [CNT_W-1:0]           retire_num,
  input  logic [WAY-1:0][PR_W-1:0]   retire_told,
  input  logic                       rollback,
  output logic [WAY-1:0][PR_W-1:0]   free_tag,
  output logic [CNT_W-1:0]           avail_num,
  output logic [FCNT_W-1:0]          free_count
);

  localparam logic [PTR_W:0]  DEPTH_P = (PTR_W + 1)'(DEPTH);
  localparam logic [FCNT_W:0] DEPTH_C = (FCNT_W + 1)'(DEPTH);

  logic [PR_W-1:0]   tag_buf [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [FCNT_W-1:0] count;

  logic [CNT_W-1:0]  d_eff;
  logic [PTR_W-1:0]  tail_next;
  logic [FCNT_W:0]   count_sum;

  // DEPTH need not be a power of two; offsets never exceed WAY < DEPTH, so one subtract wraps.
  function automatic logic [PTR_W-1:0] add_ptr(input logic [PTR_W-1:0] ptr,
                                               input logic [CNT_W-1:0] off);
    logic [PTR_W:0] s;
    s = {1'b0, ptr} + (PTR_W + 1)'(off);
    if (s >= DEPTH_P) s = s - DEPTH_P;
    return s[PTR_W-1:0];
  endfunction

  // Handshake: free_tag[0..avail_num-1] are valid this cycle; dispatch consumes the first
  // dispatch_num of them (must be <= avail_num). retire_told[0..retire_num-1] are appended at
  // the edge. Outputs depend on registered state only.
  always_comb begin
    free_tag = '0;
    for (int i = 0; i < WAY; i++) begin
      free_tag[i] = tag_buf[add_ptr(head, CNT_W'(i))];
    end
    avail_num  = (count >= FCNT_W'(WAY)) ? CNT_W'(WAY) : count[CNT_W-1:0];
    free_count = count;
  end

  always_comb begin
    d_eff     = (dispatch_num > avail_num) ? avail_num : dispatch_num;
    tail_next = add_ptr(tail, retire_num);
    count_sum = {1'b0, count} + (FCNT_W + 1)'(retire_num);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_buf[i] <= PR_W'(NUM_AR + i);
      end
      head  <= '0;
      tail  <= '0;
      count <= FCNT_W'(DEPTH);
    end else begin
      for (int i = 0; i < WAY; i++) begin
        if (CNT_W'(i) < retire_num) begin
          tag_buf[add_ptr(tail, CNT_W'(i))] <= retire_told[i];
        end
      end
      tail <= tail_next;
      // Slots between old tail and old head still hold the squashed tags, so no copy is needed.
      if (rollback) begin
        head  <= tail_next;
        count <= FCNT_W'(DEPTH);
      end else begin
        head  <= add_ptr(head, d_eff);
        count <= count + FCNT_W'(retire_num) - FCNT_W'(d_eff);
      end
    end
  end

  always @(posedge clock) begin
    if (reset_n && !rollback) begin
      assert (dispatch_num <= avail_num)
        else $error("free_list: dispatch_num %0d exceeds avail_num %0d", dispatch_num, avail_num);
      assert ((count_sum - (FCNT_W + 1)'(d_eff)) <= DEPTH_C)
        else $error("free_list: retire overflows the list");
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: reset image, dispatch, refill, wrap-around, rollback and async reset.
module tb_free_list;

  localparam int WAY    = 3;
  localparam int PR_W   = 6;
  localparam int CNT_W  = 2;
  localparam int FCNT_W = 6;

  logic                     clock;
  logic                     reset_n;
  logic [CNT_W-1:0]         dispatch_num;
  logic [CNT_W-1:0]         retire_num;
  logic [WAY-1:0][PR_W-1:0] retire_told;
  logic                     rollback;
  logic [WAY-1:0][PR_W-1:0] free_tag;
  logic [CNT_W-1:0]         avail_num;
  logic [FCNT_W-1:0]        free_count;

  int total = 0;
  int bad   = 0;

  free_list #(.WAY(3), .NUM_PR(64), .NUM_AR(32)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .dispatch_num (dispatch_num),
    .retire_num   (retire_num),
    .retire_told  (retire_told),
    .rollback     (rollback),
    .free_tag     (free_tag),
    .avail_num    (avail_num),
    .free_count   (free_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] tags3(input int t2, input int t1, input int t0);
    logic [5:0] a2, a1, a0;
    a2 = 6'(t2);
    a1 = 6'(t1);
    a0 = 6'(t0);
    return {14'd0, a2, a1, a0};
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  // One clock: drive inputs, wait for the edge, settle 1 time unit, return inputs to idle.
  task automatic cyc(input int d, input int r, input int t2, input int t1, input int t0,
                     input logic rb);
    dispatch_num   = CNT_W'(d);
    retire_num     = CNT_W'(r);
    retire_told[2] = PR_W'(t2);
    retire_told[1] = PR_W'(t1);
    retire_told[0] = PR_W'(t0);
    rollback       = rb;
    @(posedge clock);
    #1;
    dispatch_num = '0;
    retire_num   = '0;
    retire_told  = '0;
    rollback     = 1'b0;
  endtask

  initial begin
    reset_n      = 1'b0;
    dispatch_num = '0;
    retire_num   = '0;
    retire_told  = '0;
    rollback     = 1'b0;
    @(posedge clock);
    #1;
    check("reset_tags",  32'(free_tag),   tags3(34, 33, 32));
    check("reset_avail", 32'(avail_num),  32'd3);
    check("reset_count", 32'(free_count), 32'd32);
    reset_n = 1'b1;

    // Drain the list: ten dispatches of three tags each.
    for (int k = 0; k < 10; k++) begin
      check($sformatf("drain_tags_%0d", k), 32'(free_tag), tags3(34 + 3*k, 33 + 3*k, 32 + 3*k));
      cyc(3, 0, 0, 0, 0, 1'b0);
    end
    check("tail_avail", 32'(avail_num),  32'd2);
    check("tail_tags",  32'(free_tag[1]) * 64 + 32'(free_tag[0]), 32'(63 * 64 + 62));
    check("tail_count", 32'(free_count), 32'd2);
    cyc(2, 0, 0, 0, 0, 1'b0);
    check("empty_avail", 32'(avail_num),  32'd0);
    check("empty_count", 32'(free_count), 32'd0);

    // Refill from empty; visible one cycle after retire.
    cyc(0, 3, 12, 9, 5, 1'b0);
    check("refill_tags",  32'(free_tag),   tags3(12, 9, 5));
    check("refill_avail", 32'(avail_num),  32'd3);
    check("refill_count", 32'(free_count), 32'd3);

    // Build count = 10, then dispatch 3 and retire 2 together.
    cyc(0, 3, 22, 21, 20, 1'b0);
    cyc(0, 3, 25, 24, 23, 1'b0);
    cyc(0, 1, 0, 0, 26, 1'b0);
    check("ten_count", 32'(free_count), 32'd10);
    cyc(3, 2, 0, 41, 40, 1'b0);
    check("simul_count", 32'(free_count), 32'd9);
    check("simul_tags",  32'(free_tag),   tags3(22, 21, 20));
    cyc(3, 0, 0, 0, 0, 1'b0);
    cyc(3, 0, 0, 0, 0, 1'b0);
    check("append_tags",  32'(free_tag),   tags3(41, 40, 26));
    check("append_count", 32'(free_count), 32'd3);

    // Steady flow: head 9->27, tail 12->30, count stays 3.
    for (int k = 0; k < 6; k++) begin
      cyc(3, 3, 10 + 3*k, 9 + 3*k, 8 + 3*k, 1'b0);
    end
    check("flow_count", 32'(free_count), 32'd3);
    check("flow_tags",  32'(free_tag),   tags3(25, 24, 23));
    cyc(3, 0, 0, 0, 0, 1'b0);
    check("h30_avail", 32'(avail_num), 32'd0);
    // Write straddles slots 30, 31, 0; read straddles the same slots next.
    cyc(0, 3, 52, 51, 50, 1'b0);
    check("wrap_write_tags",  32'(free_tag),   tags3(52, 51, 50));
    check("wrap_write_count", 32'(free_count), 32'd3);
    cyc(3, 3, 55, 54, 53, 1'b0);
    check("wrap_read_tags",  32'(free_tag),   tags3(55, 54, 53));
    check("wrap_read_count", 32'(free_count), 32'd3);

    // Async reset between edges with count = 4.
    cyc(0, 1, 0, 0, 60, 1'b0);
    check("pre_reset_count", 32'(free_count), 32'd4);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_tags",  32'(free_tag),   tags3(34, 33, 32));
    check("async_avail", 32'(avail_num),  32'd3);
    check("async_count", 32'(free_count), 32'd32);
    #1;
    reset_n = 1'b1;

    // Rollback: dispatch 32..40, then flush with one retiring Told = 7.
    cyc(3, 0, 0, 0, 0, 1'b0);
    cyc(3, 0, 0, 0, 0, 1'b0);
    cyc(3, 0, 0, 0, 0, 1'b0);
    check("pre_rb_count", 32'(free_count), 32'd23);
    check("pre_rb_tags",  32'(free_tag),   tags3(43, 42, 41));
    cyc(3, 1, 0, 0, 7, 1'b1);
    check("rb_count", 32'(free_count), 32'd32);
    check("rb_tags",  32'(free_tag),   tags3(35, 34, 33));
    check("rb_avail", 32'(avail_num),  32'd3);
    // Walk head to slot 31 so slot 0 (holding 7) becomes visible.
    for (int k = 0; k < 10; k++) begin
      cyc(3, 0, 0, 0, 0, 1'b0);
    end
    check("rb_slot0_avail", 32'(avail_num), 32'd2);
    check("rb_slot0_tags",  32'(free_tag[1]) * 64 + 32'(free_tag[0]), 32'(7 * 64 + 63));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
